poly_packer: RTL

//   Serialises a NewHope polynomial into its byte encoding (poly_tobytes). Consumes a

---
 rtl/poly_packer_pkg.sv | 23 ++
 rtl/poly_packer_coeff_freeze.sv | 11 +
 rtl/poly_packer.sv | 78 +++++++
 3 files changed

// File: rtl/poly_packer_pkg.sv
// Shared constants and types for the NewHope polynomial byte packer.
package poly_packer_pkg;

    localparam int Q       = 12289;
    localparam int N_COEFF = 1024;
    localparam int COEFF_W = 14;
    localparam int BUF_W   = 21;
    localparam int CNT_W   = 5;
    localparam int N_BYTES = N_COEFF * 7 / 4;
    localparam int CCNT_W  = $clog2(N_COEFF) + 1;
    localparam int BCNT_W  = $clog2(N_BYTES);

    typedef logic [COEFF_W-1:0] coeff_t;
    typedef logic [BUF_W-1:0]   bitbuf_t;
    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [CCNT_W-1:0]  ccnt_t;
    typedef logic [BCNT_W-1:0]  bcnt_t;

    localparam coeff_t Q_C       = coeff_t'(Q);
    localparam ccnt_t  FRAME_C   = ccnt_t'(N_COEFF);
    localparam bcnt_t  LAST_BYTE = bcnt_t'(N_BYTES - 1);

endpackage

// File: rtl/poly_packer_coeff_freeze.sv
// Brings a 14-bit coefficient into [0,Q) with one conditional subtraction.
module coeff_freeze
    import poly_packer_pkg::*;
(
    input  logic [COEFF_W-1:0] coeff_i,
    output logic [COEFF_W-1:0] frz_o
);

    assign frz_o = (coeff_i >= Q_C) ? coeff_i - Q_C : coeff_i;

endmodule

// File: rtl/poly_packer.sv
// Packs frozen 14-bit coefficients LSB-first into bytes (4 coefficients -> 7 bytes),
// flagging the final byte of each polynomial.
module poly_packer
    import poly_packer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [COEFF_W-1:0] coeff_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [7:0]         byte_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last
);

    bitbuf_t bits_q, bits_d;
    cnt_t    cnt_q, cnt_d;
    ccnt_t   ccnt_q, ccnt_d;
    bcnt_t   bcnt_q, bcnt_d;
    coeff_t  frz;
    logic    accept, emit, frame_full, last_byte;

    coeff_freeze u_freeze (
        .coeff_i (coeff_in),
        .frz_o   (frz)
    );

    // Guard against running past the frame; only reachable if the byte side lags.
    assign frame_full = (ccnt_q == FRAME_C);
    assign in_ready   = rst & (cnt_q < cnt_t'(8)) & ~frame_full;
    assign out_valid  = rst & (cnt_q >= cnt_t'(8));
    assign last_byte  = (bcnt_q == LAST_BYTE);
    assign out_last   = out_valid & last_byte;
    assign byte_out   = bits_q[7:0];

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    always_comb begin
        bits_d = bits_q;
        cnt_d  = cnt_q;
        ccnt_d = ccnt_q;
        bcnt_d = bcnt_q;
        if (accept) begin
            // Bits above cnt are always zero, so OR places the coefficient at buf[cnt +: 14].
            bits_d = bits_q | (bitbuf_t'(frz) << cnt_q);
            cnt_d  = cnt_q + cnt_t'(COEFF_W);
            ccnt_d = ccnt_q + ccnt_t'(1);
        end else if (emit) begin
            if (last_byte) begin
                bits_d = '0;
                cnt_d  = '0;
                ccnt_d = '0;
                bcnt_d = '0;
            end else begin
                bits_d = bits_q >> 8;
                cnt_d  = cnt_q - cnt_t'(8);
                bcnt_d = bcnt_q + bcnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bits_q <= '0;
            cnt_q  <= '0;
            ccnt_q <= '0;
            bcnt_q <= '0;
        end else begin
            bits_q <= bits_d;
            cnt_q  <= cnt_d;
            ccnt_q <= ccnt_d;
            bcnt_q <= bcnt_d;
        end
    end

endmodule
